wfi_sleep_ctrl: RTL and testbench

Core-side WFI sequencer: the producer of the `wfi` status that the testbench WFI checker monitors. On retirement of a WFI instruction (`32'h10500073`), it drains outstanding fetch and memory traffic, then asserts `wfi` and drops the core clock-enable. It wakes on any pending interrupt. It sits between the retire stage, the CSR file (`mie`/`mip`) and the core clock-gate cell.

---
 rtl/wfi_sleep_ctrl.sv | 176 +++++++++++++++++
 tb/tb_wfi_sleep_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wfi_sleep_ctrl.sv
// -----------------------------------------------------------------------------
// wfi_sleep_ctrl
//
// Core-side WFI sequencer. When a WFI instruction retires and nothing prevents
// a stall, the controller waits for outstanding fetch and LSU traffic to
// drain, then reports the WFI state and gates the core clock. Any pending
// interrupt (enabled mie/mip pair or a side-band wake source) brings the core
// back through a one-cycle WAKE state.
//
// Parameters
//   XLEN           width of reg_mie / reg_mip
//   DRAIN_TIMEOUT  cycles allowed in DRAIN before aborting (1..255)
//
// Ports
//   clock              single clock; controller itself is never gated
//   reset              asynchronous, active-low reset
//   wfi_retire         one-cycle pulse: WFI retired this cycle
//   allow_wfi          1 = WFI may stall, 0 = WFI behaves as NOP
//   debug              core is in debug mode
//   single_step        dcsr.step is set
//   reg_mie, reg_mip   mie / mip CSR values
//   bus_err_int, debug_int, clint_int   side-band wake sources
//   fetch_outstanding  fetch unit has requests in flight
//   mem_outstanding    LSU has requests in flight
//   wfi                core is in WFI state (drops the cycle pending rises)
//   clock_en           core clock-gate enable, 0 = gated
//   wake               one-cycle pulse on SLEEP exit or pending-abort of DRAIN
//   timeout_err        sticky: a drain exceeded DRAIN_TIMEOUT
//   sleep_cycles       saturating count of non-pending cycles spent in SLEEP
// -----------------------------------------------------------------------------
module wfi_sleep_ctrl #(
    parameter int XLEN          = 32,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wfi_retire,
    input  logic            allow_wfi,
    input  logic            debug,
    input  logic            single_step,
    input  logic [XLEN-1:0] reg_mie,
    input  logic [XLEN-1:0] reg_mip,
    input  logic            bus_err_int,
    input  logic            debug_int,
    input  logic            clint_int,
    input  logic            fetch_outstanding,
    input  logic            mem_outstanding,
    output logic            wfi,
    output logic            clock_en,
    output logic            wake,
    output logic            timeout_err,
    output logic [31:0]     sleep_cycles
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_SLEEP = 2'b10,
        ST_WAKE  = 2'b11
    } state_t;

    // Last legal value of the drain counter before the abort fires.
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);

    state_t      state_r;
    logic [7:0]  drain_cnt_r;
    logic        clock_en_r;
    logic        wake_r;
    logic        timeout_err_r;
    logic [31:0] sleep_cycles_r;

    logic        pending_s;
    logic        drained_s;
    logic        wfi_block_s;
    logic        wfi_s;

    // Saturating 32-bit increment for the sleep-cycle counter.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

    // Wake and drain conditions, plus the reasons a retired WFI acts as a NOP.
    always_comb begin
        pending_s   = (|(reg_mie & reg_mip)) | bus_err_int | debug_int | clint_int;
        drained_s   = !fetch_outstanding && !mem_outstanding;
        wfi_block_s = pending_s || debug || single_step || !allow_wfi;
    end

    // WFI state is masked by pending in the same cycle so it never overlaps an interrupt.
    always_comb begin
        wfi_s = (state_r == ST_SLEEP) && !pending_s;
    end

    // Sequencer FSM with registered clock-enable, wake pulse, and status counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_RUN;
            drain_cnt_r    <= 8'd0;
            clock_en_r     <= 1'b1;
            wake_r         <= 1'b0;
            timeout_err_r  <= 1'b0;
            sleep_cycles_r <= 32'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    wake_r     <= 1'b0;
                    clock_en_r <= 1'b1;
                    if (wfi_retire && !wfi_block_s) begin
                        state_r     <= ST_DRAIN;
                        drain_cnt_r <= 8'd0;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    // An interrupt beats a completed drain: never sleep over a pending wake.
                    if (pending_s) begin
                        state_r    <= ST_RUN;
                        wake_r     <= 1'b1;
                        clock_en_r <= 1'b1;
                    end else if (drained_s) begin
                        state_r    <= ST_SLEEP;
                        wake_r     <= 1'b0;
                        clock_en_r <= 1'b0;
                    end else if (drain_cnt_r == DRAIN_LAST) begin
                        // Timeout abort returns silently; only the sticky flag reports it.
                        state_r       <= ST_RUN;
                        wake_r        <= 1'b0;
                        clock_en_r    <= 1'b1;
                        timeout_err_r <= 1'b1;
                    end else begin
                        state_r     <= ST_DRAIN;
                        wake_r      <= 1'b0;
                        clock_en_r  <= 1'b1;
                        drain_cnt_r <= drain_cnt_r + 8'd1;
                    end
                end
                ST_SLEEP: begin
                    if (pending_s) begin
                        state_r    <= ST_WAKE;
                        wake_r     <= 1'b1;
                        clock_en_r <= 1'b1;
                    end else begin
                        state_r        <= ST_SLEEP;
                        wake_r         <= 1'b0;
                        clock_en_r     <= 1'b0;
                        sleep_cycles_r <= sat_inc32(sleep_cycles_r);
                    end
                end
                ST_WAKE: begin
                    state_r    <= ST_RUN;
                    wake_r     <= 1'b0;
                    clock_en_r <= 1'b1;
                end
                default: begin
                    state_r    <= ST_RUN;
                    wake_r     <= 1'b0;
                    clock_en_r <= 1'b1;
                end
            endcase
        end
    end

    assign wfi          = wfi_s;
    assign clock_en     = clock_en_r;
    assign wake         = wake_r;
    assign timeout_err  = timeout_err_r;
    assign sleep_cycles = sleep_cycles_r;

endmodule

// File: tb/tb_wfi_sleep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wfi_sleep_ctrl
//
// Directed scoreboard bench. Stimulus pushes hand-computed expectations, each
// tagged with the cycle at which it must hold; a separate monitor pops and
// compares them at the falling edge of that cycle. The monitor also watches
// two invariants every cycle (wfi never with pending, wake never two cycles
// in a row) across directed and random traffic.
// -----------------------------------------------------------------------------
module tb_wfi_sleep_ctrl;

    localparam int XLEN = 32;
    localparam int DT   = 8;

    localparam int F_WFI  = 0;
    localparam int F_CEN  = 1;
    localparam int F_WAKE = 2;
    localparam int F_TERR = 3;
    localparam int F_SLP  = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            wfi_retire;
    logic            allow_wfi;
    logic            debug;
    logic            single_step;
    logic [XLEN-1:0] reg_mie;
    logic [XLEN-1:0] reg_mip;
    logic            bus_err_int;
    logic            debug_int;
    logic            clint_int;
    logic            fetch_outstanding;
    logic            mem_outstanding;
    logic            wfi;
    logic            clock_en;
    logic            wake;
    logic            timeout_err;
    logic [31:0]     sleep_cycles;

    typedef struct {
        int          cyc;
        int          fld;
        logic [31:0] val;
        string       nm;
    } exp_t;

    exp_t sb_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic done   = 1'b0;

    wfi_sleep_ctrl #(.XLEN(XLEN), .DRAIN_TIMEOUT(DT)) dut (
        .clock             (clock),
        .reset             (reset),
        .wfi_retire        (wfi_retire),
        .allow_wfi         (allow_wfi),
        .debug             (debug),
        .single_step       (single_step),
        .reg_mie           (reg_mie),
        .reg_mip           (reg_mip),
        .bus_err_int       (bus_err_int),
        .debug_int         (debug_int),
        .clint_int         (clint_int),
        .fetch_outstanding (fetch_outstanding),
        .mem_outstanding   (mem_outstanding),
        .wfi               (wfi),
        .clock_en          (clock_en),
        .wake              (wake),
        .timeout_err       (timeout_err),
        .sleep_cycles      (sleep_cycles)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] act(input int f);
        case (f)
            F_WFI:   return {31'd0, wfi};
            F_CEN:   return {31'd0, clock_en};
            F_WAKE:  return {31'd0, wake};
            F_TERR:  return {31'd0, timeout_err};
            default: return sleep_cycles;
        endcase
    endfunction

    task automatic exp_at(input int d, input int f, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc = cyc + d;
        e.fld = f;
        e.val = v;
        e.nm  = nm;
        sb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: scoreboard compare, invariants, final checks and summary.
    initial begin
        int   viol;
        int   wfi_seen;
        int   wake_seen;
        logic prev_wake;
        logic pend;
        viol      = 0;
        wfi_seen  = 0;
        wake_seen = 0;
        prev_wake = 1'b0;
        forever begin
            @(negedge clock);
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].cyc <= cyc) begin
                    checks++;
                    if (sb_q[i].cyc < cyc || act(sb_q[i].fld) !== sb_q[i].val) begin
                        errors++;
                        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, due %0d)",
                                 sb_q[i].nm, act(sb_q[i].fld), sb_q[i].val, cyc, sb_q[i].cyc);
                    end
                    sb_q.delete(i);
                end
            end
            pend = (|(reg_mie & reg_mip)) | bus_err_int | debug_int | clint_int;
            if (wfi === 1'b1 && pend) viol++;
            if (wake === 1'b1 && prev_wake === 1'b1) viol++;
            if (wfi === 1'b1) wfi_seen++;
            if (wake === 1'b1) wake_seen++;
            prev_wake = wake;
            if (done) begin
                checks++;
                if (viol != 0) begin
                    errors++;
                    $display("FAIL invariant: got %0d violations, expected 0", viol);
                end
                checks++;
                if (wfi_seen == 0) begin
                    errors++;
                    $display("FAIL wfi_activity: got %0d wfi cycles, expected > 0", wfi_seen);
                end
                checks++;
                if (wake_seen == 0) begin
                    errors++;
                    $display("FAIL wake_activity: got %0d wake pulses, expected > 0", wake_seen);
                end
                checks++;
                if (sb_q.size() != 0) begin
                    errors++;
                    $display("FAIL sb_drain: got %0d unchecked entries, expected 0", sb_q.size());
                end
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    // Stimulus.
    initial begin
        reset = 1'b0;
        wfi_retire = 1'b0; allow_wfi = 1'b1; debug = 1'b0; single_step = 1'b0;
        reg_mie = '0; reg_mip = '0;
        bus_err_int = 1'b0; debug_int = 1'b0; clint_int = 1'b0;
        fetch_outstanding = 1'b0; mem_outstanding = 1'b0;

        // Reset state.
        step(1);
        exp_at(0, F_WFI,  32'd0, "rst_wfi");
        exp_at(0, F_CEN,  32'd1, "rst_cen");
        exp_at(0, F_WAKE, 32'd0, "rst_wake");
        exp_at(0, F_TERR, 32'd0, "rst_terr");
        exp_at(0, F_SLP,  32'd0, "rst_slp");
        step(1); reset = 1'b1;
        step(1);

        // T1: minimum latency to sleep, then wake by mie[7]/mip[7].
        wfi_retire = 1'b1;
        exp_at(1, F_WFI, 32'd0, "t1_drain_wfi");
        exp_at(1, F_CEN, 32'd1, "t1_drain_cen");
        exp_at(2, F_WFI, 32'd1, "t1_sleep_wfi");
        exp_at(2, F_CEN, 32'd0, "t1_sleep_cen");
        step(1); wfi_retire = 1'b0;
        step(2);
        reg_mie[7] = 1'b1; reg_mip[7] = 1'b1;
        exp_at(0, F_WFI,  32'd0, "t1_pend_wfi");
        exp_at(0, F_CEN,  32'd0, "t1_pend_cen");
        exp_at(0, F_SLP,  32'd1, "t1_slp");
        exp_at(1, F_WAKE, 32'd1, "t1_wake");
        exp_at(1, F_CEN,  32'd1, "t1_wake_cen");
        exp_at(2, F_WAKE, 32'd0, "t1_wake_once");
        exp_at(2, F_SLP,  32'd1, "t1_slp_hold");
        step(1); reg_mie = '0; reg_mip = '0;
        step(3);

        // T2: 7-cycle drain (drained exactly at the last allowed count), 20 sleep cycles.
        wfi_retire = 1'b1; mem_outstanding = 1'b1;
        exp_at(1,  F_CEN,  32'd1,  "t2_drain_cen");
        exp_at(4,  F_WFI,  32'd0,  "t2_mid_drain_wfi");
        exp_at(8,  F_WFI,  32'd0,  "t2_last_drain_wfi");
        exp_at(9,  F_WFI,  32'd1,  "t2_sleep_wfi");
        exp_at(9,  F_TERR, 32'd0,  "t2_no_timeout");
        exp_at(29, F_SLP,  32'd21, "t2_slp20");
        step(1); wfi_retire = 1'b0;
        step(7); mem_outstanding = 1'b0;
        step(21);
        clint_int = 1'b1;
        exp_at(0, F_WFI,  32'd0,  "t2_clint_wfi");
        exp_at(1, F_WAKE, 32'd1,  "t2_wake");
        exp_at(1, F_SLP,  32'd21, "t2_slp_hold");
        step(1); clint_int = 1'b0;
        step(3);

        // T3: WFI treated as NOP for clint_int, debug, single_step, !allow_wfi.
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       clint_int   = 1'b1;
                1:       debug       = 1'b1;
                2:       single_step = 1'b1;
                default: allow_wfi   = 1'b0;
            endcase
            wfi_retire = 1'b1;
            exp_at(1, F_WFI,  32'd0, $sformatf("t3_wfi1_%0d", i));
            exp_at(1, F_CEN,  32'd1, $sformatf("t3_cen1_%0d", i));
            exp_at(1, F_WAKE, 32'd0, $sformatf("t3_wake1_%0d", i));
            exp_at(2, F_WFI,  32'd0, $sformatf("t3_wfi2_%0d", i));
            exp_at(2, F_CEN,  32'd1, $sformatf("t3_cen2_%0d", i));
            exp_at(2, F_WAKE, 32'd0, $sformatf("t3_wake2_%0d", i));
            step(1);
            wfi_retire = 1'b0; clint_int = 1'b0; debug = 1'b0;
            single_step = 1'b0; allow_wfi = 1'b1;
            step(3);
        end

        // T4: pending and drained together in DRAIN -> abort with wake.
        wfi_retire = 1'b1; mem_outstanding = 1'b1;
        step(1); wfi_retire = 1'b0;
        step(1);
        bus_err_int = 1'b1; mem_outstanding = 1'b0;
        exp_at(1, F_WAKE, 32'd1,  "t4_abort_wake");
        exp_at(1, F_CEN,  32'd1,  "t4_abort_cen");
        exp_at(1, F_WFI,  32'd0,  "t4_abort_wfi");
        exp_at(1, F_SLP,  32'd21, "t4_slp");
        exp_at(2, F_WAKE, 32'd0,  "t4_wake_once");
        exp_at(2, F_CEN,  32'd1,  "t4_run_cen");
        step(1); bus_err_int = 1'b0;
        step(3);

        // T5: fetch stuck -> timeout after exactly DT drain cycles, no wake.
        wfi_retire = 1'b1; fetch_outstanding = 1'b1;
        exp_at(8,  F_TERR, 32'd0, "t5_pre_terr");
        exp_at(8,  F_CEN,  32'd1, "t5_drain_cen");
        exp_at(9,  F_TERR, 32'd1, "t5_terr");
        exp_at(9,  F_WAKE, 32'd0, "t5_no_wake");
        exp_at(10, F_WAKE, 32'd0, "t5_no_wake2");
        exp_at(12, F_CEN,  32'd1, "t5_run_cen");
        exp_at(20, F_TERR, 32'd1, "t5_sticky");
        step(1); wfi_retire = 1'b0;
        step(12); fetch_outstanding = 1'b0;
        step(9);

        // T6: asynchronous reset mid-SLEEP with sleep_cycles = 5.
        reset = 1'b0;
        exp_at(0, F_TERR, 32'd0, "t6_rst_terr");
        exp_at(0, F_SLP,  32'd0, "t6_rst_slp");
        step(1); reset = 1'b1;
        step(1);
        wfi_retire = 1'b1;
        exp_at(2, F_WFI, 32'd1, "t6_sleep");
        exp_at(7, F_SLP, 32'd5, "t6_slp5");
        exp_at(7, F_WFI, 32'd1, "t6_sleep_hold");
        step(1); wfi_retire = 1'b0;
        step(6);
        @(negedge clock); #1;
        reset = 1'b0;
        exp_at(1, F_WFI,  32'd0, "t6_rst_wfi");
        exp_at(1, F_CEN,  32'd1, "t6_rst_cen");
        exp_at(1, F_SLP,  32'd0, "t6_rst_slp0");
        exp_at(1, F_WAKE, 32'd0, "t6_rst_wake");
        step(1); reset = 1'b1;
        step(1);
        wfi_retire = 1'b1;
        exp_at(2, F_WFI, 32'd1, "t6_resleep");
        exp_at(2, F_CEN, 32'd0, "t6_resleep_cen");
        exp_at(3, F_SLP, 32'd1, "t6_recount");
        step(1); wfi_retire = 1'b0;
        step(3);
        // One-cycle debug_int glitch: exits via WAKE, no re-entry.
        debug_int = 1'b1;
        exp_at(0, F_WFI,  32'd0, "t6_glitch_wfi");
        exp_at(1, F_WAKE, 32'd1, "t6_wake");
        exp_at(3, F_CEN,  32'd1, "t6_no_reentry");
        exp_at(3, F_WFI,  32'd0, "t6_no_reentry_wfi");
        step(1); debug_int = 1'b0;
        step(4);

        // Random traffic for the invariant monitor.
        for (int n = 0; n < 3000; n++) begin
            wfi_retire        = ($urandom_range(0, 15) == 0);
            allow_wfi         = ($urandom_range(0, 7) != 0);
            debug             = ($urandom_range(0, 31) == 0);
            single_step       = ($urandom_range(0, 31) == 0);
            reg_mie           = $urandom;
            reg_mip           = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
            bus_err_int       = ($urandom_range(0, 63) == 0);
            debug_int         = ($urandom_range(0, 63) == 0);
            clint_int         = ($urandom_range(0, 63) == 0);
            fetch_outstanding = ($urandom_range(0, 3) == 0);
            mem_outstanding   = ($urandom_range(0, 3) == 0);
            step(1);
        end
        wfi_retire = 1'b0; debug = 1'b0; single_step = 1'b0;
        reg_mie = '0; reg_mip = '0;
        bus_err_int = 1'b0; debug_int = 1'b0; clint_int = 1'b0;
        fetch_outstanding = 1'b0; mem_outstanding = 1'b0; allow_wfi = 1'b1;
        step(4);
        done = 1'b1;
        step(4);
    end

endmodule
